touch_key_filter: RTL and testbench

Input conditioning stage between the raw active-low touch-key pad and the downstream edge-detect/LED-toggle logic. It synchronises `touch_key` into `sys_clk`, debounces it with a counter-based state machine, and drives a clean active-low level, `key_out`, that downstream logic can edge-detect directly. It also produces single-cycle event pulses for debounced press, debounced release and long press.

---
 rtl/touch_key_filter.sv | 108 ++++++++++
 tb/tb_touch_key_filter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/touch_key_filter.sv
// Touch-pad conditioning: 2-flop synchroniser, counter-based debounce FSM,
// clean active-low level plus single-cycle press / release / long-press pulses.
module touch_key_filter #(
    parameter int CNT_MAX  = 999_999,
    parameter int LONG_MAX = 49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic touch_key,
    output logic key_out,
    output logic key_flag,
    output logic key_rls,
    output logic key_long
);

    // A 1-cycle debounce (CNT_MAX = 0) still needs a 1-bit counter to exist.
    localparam int DB_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int HOLD_W = $clog2(LONG_MAX + 1);

    localparam logic [DB_W-1:0]   DB_TOP   = DB_W'(CNT_MAX);
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(LONG_MAX);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_DB   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] RELEASE_DB = 2'd3;

    logic              sync1;
    logic              sync2;
    logic [1:0]        state_reg;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= touch_key;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            long_done_reg <= 1'b0;
            key_out       <= 1'b1;
            key_flag      <= 1'b0;
            key_rls       <= 1'b0;
            key_long      <= 1'b0;
        end else begin
            key_flag <= 1'b0;
            key_rls  <= 1'b0;
            key_long <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!sync2) begin
                        state_reg <= PRESS_DB;
                        db_cnt    <= '0;
                    end
                end
                PRESS_DB: begin
                    if (sync2) begin
                        state_reg <= IDLE;
                        db_cnt    <= '0;
                    end else if (db_cnt == DB_TOP) begin
                        state_reg     <= HELD;
                        key_out       <= 1'b0;
                        key_flag      <= 1'b1;
                        hold_cnt      <= '0;
                        long_done_reg <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (sync2) begin
                        state_reg <= RELEASE_DB;
                        db_cnt    <= '0;
                    end else if (hold_cnt < HOLD_TOP) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (!long_done_reg) begin
                        // Counter saturated; fire the long-press event only once per press.
                        key_long      <= 1'b1;
                        long_done_reg <= 1'b1;
                    end
                end
                RELEASE_DB: begin
                    if (!sync2) begin
                        state_reg <= HELD;
                    end else if (db_cnt == DB_TOP) begin
                        state_reg <= IDLE;
                        key_out   <= 1'b1;
                        key_rls   <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_key_filter.sv
// Directed bench for touch_key_filter with CNT_MAX=9, LONG_MAX=49:
// press/release latency, bounce rejection, long press, release glitch, resets.
module tb_touch_key_filter;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic touch_key = 1'b0;
    logic key_out;
    logic key_flag;
    logic key_rls;
    logic key_long;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_flag   = 0;
    int n_rls    = 0;
    int n_long   = 0;
    int n_low    = 0;
    int n_ovl    = 0;
    int t_flag   = -1;
    int t_rls    = -1;
    int t_long   = -1;
    int t0       = 0;
    int t1       = 0;

    touch_key_filter #(
        .CNT_MAX  (9),
        .LONG_MAX (49)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .touch_key (touch_key),
        .key_out   (key_out),
        .key_flag  (key_flag),
        .key_rls   (key_rls),
        .key_long  (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    // One edge: sample 1 time unit after it and log pulse activity.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (key_flag) begin n_flag++; t_flag = cyc; end
        if (key_rls)  begin n_rls++;  t_rls  = cyc; end
        if (key_long) begin n_long++; t_long = cyc; end
        if (!key_out) n_low++;
        if (int'(key_flag) + int'(key_rls) + int'(key_long) > 1) n_ovl++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_stats();
        n_flag = 0; n_rls = 0; n_long = 0; n_low = 0;
        t_flag = -1; t_rls = -1; t_long = -1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
        $display("check %-22s observed %0d expected %0d", tag, observed, expected);
    endtask

    initial begin
        // Reset held with key pressed: outputs stay idle.
        ticks(3);
        check("rst_key_out", int'(key_out), 1);
        check("rst_key_flag", int'(key_flag), 0);
        check("rst_key_rls", int'(key_rls), 0);
        check("rst_key_long", int'(key_long), 0);

        // After release the held key is debounced: flag at E12 after first sampling edge.
        sys_rst_n = 1'b1;
        clear_stats();
        t0 = cyc;
        ticks(12);
        check("rst_pre_key_out", int'(key_out), 1);
        check("rst_pre_flags", n_flag, 0);
        tick();
        check("rst_flag_e12", int'(key_flag), 1);
        check("rst_keyout_e12", int'(key_out), 0);
        tick();
        check("rst_flag_1cyc", int'(key_flag), 0);

        touch_key = 1'b1;
        ticks(12);
        check("rls_pre_key_out", int'(key_out), 0);
        tick();
        check("rls_pulse_e12", int'(key_rls), 1);
        check("rls_keyout_e12", int'(key_out), 1);
        tick();
        check("rls_1cyc", int'(key_rls), 0);

        // Clean press/release, 30 cycles low.
        clear_stats();
        touch_key = 1'b0;
        t0 = cyc;
        ticks(30);
        touch_key = 1'b1;
        t1 = cyc;
        ticks(20);
        check("clean_n_flag", n_flag, 1);
        check("clean_flag_time", t_flag - t0, 13);
        check("clean_n_rls", n_rls, 1);
        check("clean_rls_time", t_rls - t1, 13);
        check("clean_low_cycles", n_low, t_rls - t_flag);
        check("clean_n_long", n_long, 0);
        check("clean_key_out", int'(key_out), 1);

        // Bounce: 9-cycle lows separated by 3-cycle highs.
        clear_stats();
        for (int r = 0; r < 5; r++) begin
            touch_key = 1'b0;
            ticks(9);
            touch_key = 1'b1;
            ticks(3);
        end
        ticks(5);
        check("bounce_n_flag", n_flag, 0);
        check("bounce_n_rls", n_rls, 0);
        check("bounce_n_long", n_long, 0);
        check("bounce_low_cycles", n_low, 0);

        // Long press, 100 cycles low.
        clear_stats();
        touch_key = 1'b0;
        t0 = cyc;
        ticks(100);
        touch_key = 1'b1;
        t1 = cyc;
        ticks(20);
        check("long_n_flag", n_flag, 1);
        check("long_flag_time", t_flag - t0, 13);
        check("long_n_long", n_long, 1);
        check("long_after_flag", t_long - t_flag, 50);
        check("long_n_rls", n_rls, 1);
        check("long_rls_time", t_rls - t1, 13);
        check("long_key_out", int'(key_out), 1);

        // Release glitch: 5-cycle high while held returns to HELD.
        clear_stats();
        touch_key = 1'b0;
        ticks(20);
        touch_key = 1'b1;
        ticks(5);
        touch_key = 1'b0;
        ticks(10);
        check("glitch_n_flag", n_flag, 1);
        check("glitch_n_rls", n_rls, 0);
        check("glitch_key_out", int'(key_out), 0);
        touch_key = 1'b1;
        t1 = cyc;
        ticks(20);
        check("glitch_rls_time", t_rls - t1, 13);
        check("glitch_n_long", n_long, 0);
        check("glitch_end_out", int'(key_out), 1);

        // Reset in the middle of press debounce, key still low.
        clear_stats();
        touch_key = 1'b0;
        ticks(8);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_key_out", int'(key_out), 1);
        ticks(2);
        check("mid_rst_flag", n_flag, 0);
        sys_rst_n = 1'b1;
        t1 = cyc;
        ticks(20);
        check("mid_n_flag", n_flag, 1);
        check("mid_flag_time", t_flag - t1, 13);
        check("mid_key_out", int'(key_out), 0);
        touch_key = 1'b1;
        ticks(20);
        check("mid_end_key_out", int'(key_out), 1);

        check("pulse_overlap", n_ovl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
